// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, pattern-mode encoding
// and palette sizing helper.
package vga_pkg;

  // Default 640x480@60 raster (25.175 MHz pixel clock).
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  // Pattern modes selected by the mode input.
  typedef enum logic [1:0] {
    MODE_HBANDS  = 2'd0,
    MODE_VBANDS  = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SCROLL  = 2'd3
  } mode_e;

  // Total palette width: one {R,G,B} entry per band.
  function automatic int unsigned palette_w(input int unsigned n_bands,
                                            input int unsigned color_w);
    return n_bands * 3 * color_w;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing: horizontal/vertical counters plus decoded sync, active,
// line/frame boundary and origin strobes. All decodes are combinational from
// the counter state; the caller registers them together with the pixel data.
module vga_timing import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic line_end_o,
  output logic frame_end_o,
  output logic origin_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic active_o
);

  localparam int unsigned HTotal     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCntW      = $clog2(HTotal);
  localparam int unsigned VCntW      = $clog2(VTotal);
  localparam int unsigned HSyncFirst = H_ACTIVE + H_FP;
  localparam int unsigned HSyncLast  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VSyncFirst = V_ACTIVE + V_FP;
  localparam int unsigned VSyncLast  = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [HCntW-1:0] hcnt_q, hcnt_d;
  logic [VCntW-1:0] vcnt_q, vcnt_d;

  assign line_end_o  = (hcnt_q == HCntW'(HTotal - 1));
  assign frame_end_o = line_end_o && (vcnt_q == VCntW'(VTotal - 1));
  assign origin_o    = (hcnt_q == '0) && (vcnt_q == '0);

  // Inclusive last-index compares keep the constants inside the counter width.
  assign hsync_o  = !((hcnt_q >= HCntW'(HSyncFirst)) && (hcnt_q <= HCntW'(HSyncLast)));
  assign vsync_o  = !((vcnt_q >= VCntW'(VSyncFirst)) && (vcnt_q <= VCntW'(VSyncLast)));
  assign active_o = (hcnt_q <= HCntW'(H_ACTIVE - 1)) && (vcnt_q <= VCntW'(V_ACTIVE - 1));

  // Advance the raster position; vcnt steps when hcnt wraps.
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (line_end_o) begin
      hcnt_d = '0;
      vcnt_d = frame_end_o ? '0 : vcnt_q + 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/pattern_generator.sv
// Parametrised VGA test-pattern generator. Renders N_BANDS colour bands from a
// run-time palette as horizontal bands, vertical bands, a checkerboard or
// scrolling horizontal bands. Every output is registered one cycle after the
// raster counter state so sync, display-area and colour stay aligned.
module pattern_generator import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE   = DefHActive,
  parameter int unsigned H_FP       = DefHFp,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BP       = DefHBp,
  parameter int unsigned V_ACTIVE   = DefVActive,
  parameter int unsigned V_FP       = DefVFp,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BP       = DefVBp,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned N_BANDS    = 3,
  parameter int unsigned SCROLL_DIV = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [1:0]                             mode,
  input  logic [palette_w(N_BANDS, COLOR_W)-1:0] palette,
  output logic                                   vga_h_sync,
  output logic                                   vga_v_sync,
  output logic [COLOR_W-1:0]                     vga_R,
  output logic [COLOR_W-1:0]                     vga_G,
  output logic [COLOR_W-1:0]                     vga_B,
  output logic                                   in_display_area,
  output logic                                   frame_start
);

  localparam int unsigned EntryW = 3 * COLOR_W;
  localparam int unsigned PalW   = palette_w(N_BANDS, COLOR_W);
  localparam int unsigned BandW  = H_ACTIVE / N_BANDS;
  localparam int unsigned BandH  = V_ACTIVE / N_BANDS;
  localparam int unsigned IdxW   = $clog2(N_BANDS);
  localparam int unsigned SumW   = IdxW + 1;
  localparam int unsigned HPixW  = $clog2(BandW + 1);
  localparam int unsigned VRowW  = $clog2(BandH + 1);
  localparam int unsigned FDivW  = $clog2(SCROLL_DIV + 1);
  localparam logic [IdxW-1:0] LastBand = IdxW'(N_BANDS - 1);

  if ((N_BANDS < 2) || (N_BANDS > 16)) begin : gen_bad_n_bands
    $error("pattern_generator: N_BANDS must lie in 2..16");
  end
  if (SCROLL_DIV < 1) begin : gen_bad_scroll_div
    $error("pattern_generator: SCROLL_DIV must be at least 1");
  end
  if ((BandW < 1) || (BandH < 1)) begin : gen_bad_geometry
    $error("pattern_generator: active area smaller than N_BANDS");
  end

  // (a + b) mod N_BANDS for operands already below N_BANDS.
  function automatic logic [IdxW-1:0] add_mod(input logic [IdxW-1:0] a,
                                              input logic [IdxW-1:0] b);
    logic [SumW-1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= SumW'(N_BANDS)) begin
      sum = sum - SumW'(N_BANDS);
    end
    return sum[IdxW-1:0];
  endfunction

  logic line_end, frame_end, origin, hsync, vsync, active;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i       (clk),
    .rst_ni      (reset),
    .line_end_o  (line_end),
    .frame_end_o (frame_end),
    .origin_o    (origin),
    .hsync_o     (hsync),
    .vsync_o     (vsync),
    .active_o    (active)
  );

  logic [HPixW-1:0]  hpix_q, hpix_d;
  logic [IdxW-1:0]   hband_q, hband_d;
  logic [VRowW-1:0]  vrow_q, vrow_d;
  logic [IdxW-1:0]   vband_q, vband_d;
  logic [FDivW-1:0]  fdiv_q, fdiv_d;
  logic [IdxW-1:0]   scroll_q, scroll_d;
  mode_e             mode_q, mode_d;
  logic [PalW-1:0]   pal_q, pal_d;
  logic [IdxW-1:0]   idx;
  logic [EntryW-1:0] entry;

  logic              hsync_q, vsync_q, de_q, fs_q;
  logic [EntryW-1:0] rgb_q;

  // Column band: step every BandW pixels, last band absorbs the remainder.
  always_comb begin
    hpix_d  = hpix_q;
    hband_d = hband_q;
    if (line_end) begin
      hpix_d  = '0;
      hband_d = '0;
    end else if (hband_q != LastBand) begin
      if (hpix_q == HPixW'(BandW - 1)) begin
        hpix_d  = '0;
        hband_d = hband_q + 1'b1;
      end else begin
        hpix_d = hpix_q + 1'b1;
      end
    end
  end

  // Row band: step every BandH lines, last band absorbs the remainder.
  always_comb begin
    vrow_d  = vrow_q;
    vband_d = vband_q;
    if (frame_end) begin
      vrow_d  = '0;
      vband_d = '0;
    end else if (line_end && (vband_q != LastBand)) begin
      if (vrow_q == VRowW'(BandH - 1)) begin
        vrow_d  = '0;
        vband_d = vband_q + 1'b1;
      end else begin
        vrow_d = vrow_q + 1'b1;
      end
    end
  end

  // Frame divider and scroll offset, advanced at every frame end in all modes.
  always_comb begin
    fdiv_d   = fdiv_q;
    scroll_d = scroll_q;
    if (frame_end) begin
      if (fdiv_q == FDivW'(SCROLL_DIV - 1)) begin
        fdiv_d   = '0;
        scroll_d = (scroll_q == LastBand) ? '0 : scroll_q + 1'b1;
      end else begin
        fdiv_d = fdiv_q + 1'b1;
      end
    end
  end

  // Shadow mode/palette: loaded at the origin and also used for that pixel,
  // so the whole frame renders with one consistent setting.
  always_comb begin
    mode_d = origin ? mode_e'(mode) : mode_q;
    pal_d  = origin ? palette : pal_q;
  end

  // Colour index selection and palette lookup.
  always_comb begin
    idx = vband_q;
    case (mode_d)
      MODE_HBANDS:  idx = vband_q;
      MODE_VBANDS:  idx = hband_q;
      MODE_CHECKER: idx = add_mod(hband_q, vband_q);
      MODE_SCROLL:  idx = add_mod(vband_q, scroll_q);
      default:      idx = vband_q;
    endcase
    entry = pal_d[idx * EntryW +: EntryW];
  end

  // Band, scroll and shadow state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpix_q   <= '0;
      hband_q  <= '0;
      vrow_q   <= '0;
      vband_q  <= '0;
      fdiv_q   <= '0;
      scroll_q <= '0;
      mode_q   <= MODE_HBANDS;
      pal_q    <= '0;
    end else begin
      hpix_q   <= hpix_d;
      hband_q  <= hband_d;
      vrow_q   <= vrow_d;
      vband_q  <= vband_d;
      fdiv_q   <= fdiv_d;
      scroll_q <= scroll_d;
      mode_q   <= mode_d;
      pal_q    <= pal_d;
    end
  end

  // Output register stage; colour forced to black outside the active area.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      de_q    <= active;
      fs_q    <= origin;
      rgb_q   <= active ? entry : '0;
    end
  end

  assign vga_h_sync      = hsync_q;
  assign vga_v_sync      = vsync_q;
  assign in_display_area = de_q;
  assign frame_start     = fs_q;
  assign vga_R           = rgb_q[EntryW-1 -: COLOR_W];
  assign vga_G           = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_B           = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator. The main instance uses a shrunken raster so
// many frames fit in a short run; a second instance keeps the full 640-pixel
// line to exercise 7-band column geometry.
module tb_pattern_generator;

  localparam int HA = 20, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 11, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int NB = 3, CW = 4, SD = 4;
  localparam int EW = 3 * CW, PW = NB * EW;
  localparam int BW = HA / NB, BH = VA / NB;
  localparam int NB7 = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [PW-1:0] palette;
  logic hs, vs, de, fs;
  logic [CW-1:0] r, g, b;

  logic [1:0] mode7 = 2'd1;
  logic [NB7*EW-1:0] palette7;
  logic hs7, vs7, de7, fs7;
  logic [CW-1:0] r7, g7, b7;

  int n_cmp = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;
  logic [PW-1:0] pal_base;

  always #5 clk = ~clk;

  pattern_generator #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .COLOR_W(CW), .N_BANDS(NB), .SCROLL_DIV(SD)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .palette(palette),
    .vga_h_sync(hs), .vga_v_sync(vs), .vga_R(r), .vga_G(g), .vga_B(b),
    .in_display_area(de), .frame_start(fs)
  );

  pattern_generator #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(7), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_W(CW), .N_BANDS(NB7), .SCROLL_DIV(SD)
  ) dut7 (
    .clk(clk), .reset(reset), .mode(mode7), .palette(palette7),
    .vga_h_sync(hs7), .vga_v_sync(vs7), .vga_R(r7), .vga_G(g7), .vga_B(b7),
    .in_display_area(de7), .frame_start(fs7)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ent_rgb(input int e);
    if (e < 0) return '0;
    return pal_base[e*EW +: EW];
  endfunction

  // Reference pixel colour from raster position, frames since reset and the
  // frame's mode/palette, using plain division and modulo.
  function automatic logic [EW-1:0] model_rgb(input int h, input int v, input int frames,
                                              input logic [1:0] md, input logic [PW-1:0] pal);
    int vb, hb, sc, idx;
    if (h >= HA || v >= VA) return '0;
    vb = v / BH;
    if (vb > NB - 1) vb = NB - 1;
    hb = h / BW;
    if (hb > NB - 1) hb = NB - 1;
    sc = (frames / SD) % NB;
    case (md)
      2'd0:    idx = vb;
      2'd1:    idx = hb;
      2'd2:    idx = (hb + vb) % NB;
      default: idx = (vb + sc) % NB;
    endcase
    return pal[idx*EW +: EW];
  endfunction

  int m_h, m_v, m_frames;
  logic [1:0] m_mode;
  logic [PW-1:0] m_pal;
  logic e_hs, e_vs, e_de, e_fs;
  logic [EW-1:0] e_rgb;

  // Reference model: expected registered outputs for the current position.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_h <= 0; m_v <= 0; m_frames <= 0; m_mode <= 2'd0; m_pal <= '0;
      e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0; e_fs <= 1'b0; e_rgb <= '0;
    end else begin
      m_mode <= (m_h == 0 && m_v == 0) ? mode : m_mode;
      m_pal  <= (m_h == 0 && m_v == 0) ? palette : m_pal;
      e_rgb  <= model_rgb(m_h, m_v, m_frames,
                          (m_h == 0 && m_v == 0) ? mode : m_mode,
                          (m_h == 0 && m_v == 0) ? palette : m_pal);
      e_hs <= !(m_h >= HA + HFP && m_h < HA + HFP + HS);
      e_vs <= !(m_v >= VA + VFP && m_v < VA + VFP + VS);
      e_de <= (m_h < HA) && (m_v < VA);
      e_fs <= (m_h == 0) && (m_v == 0);
      if (m_h == HT - 1) begin
        m_h <= 0;
        if (m_v == VT - 1) begin
          m_v <= 0;
          m_frames <= m_frames + 1;
        end else begin
          m_v <= m_v + 1;
        end
      end else begin
        m_h <= m_h + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) check("stream", {hs, vs, de, fs, r, g, b}, {e_hs, e_vs, e_de, e_fs, e_rgb});
  end

  task automatic wait_fs();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FT + 8; i++) begin
      @(negedge clk);
      if (fs === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("frame_start_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [1:0] md;
    int v;
    int h;
    int ent;
  } vec_t;
  vec_t tbl[19];

  int hs_fall[$];
  int vs_fall[$];
  int hs_low, vs_low, de_cnt, hs_per, vs_per, act;
  logic phs, pvs;
  int cols7[7];
  int ents7[7];

  initial begin
    tbl[0]  = '{2'd0, 0, 0, 0};
    tbl[1]  = '{2'd0, 2, 5, 0};
    tbl[2]  = '{2'd0, 3, 0, 1};
    tbl[3]  = '{2'd0, 5, 19, 1};
    tbl[4]  = '{2'd0, 6, 0, 2};
    tbl[5]  = '{2'd0, 10, 19, 2};
    tbl[6]  = '{2'd0, 0, 20, -1};
    tbl[7]  = '{2'd0, 11, 0, -1};
    tbl[8]  = '{2'd1, 0, 5, 0};
    tbl[9]  = '{2'd1, 0, 6, 1};
    tbl[10] = '{2'd1, 4, 11, 1};
    tbl[11] = '{2'd1, 4, 12, 2};
    tbl[12] = '{2'd1, 10, 19, 2};
    tbl[13] = '{2'd2, 0, 6, 1};
    tbl[14] = '{2'd2, 3, 6, 2};
    tbl[15] = '{2'd2, 6, 6, 0};
    tbl[16] = '{2'd2, 10, 19, 1};
    tbl[17] = '{2'd2, 3, 0, 1};
    tbl[18] = '{2'd2, 14, 26, -1};
    cols7 = '{0, 90, 91, 545, 546, 639, 640};
    ents7 = '{0, 0, 1, 5, 6, 6, -1};

    pal_base = {12'hF00, 12'hFFF, 12'h00F};
    palette  = pal_base;
    for (int k = 0; k < NB7; k++) palette7[k*EW +: EW] = 12'(12'h111 * (k + 1));

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_state", {hs, vs, de, fs, r, g, b}, 32'hC000);
    chk_on = 1'b1;
    reset = 1'b1;

    // 7-band column geometry on the full-width instance.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fs7 === 1'b1) break;
    end
    check("dut7_frame_start", 32'(fs7), 32'd1);
    for (int c = 0; c <= 640; c++) begin
      if (c > 0) @(negedge clk);
      for (int j = 0; j < 7; j++) begin
        if (cols7[j] == c)
          check($sformatf("dut7_col%0d", c), {r7, g7, b7},
                (ents7[j] < 0) ? 32'd0 : 32'(12'h111 * (ents7[j] + 1)));
      end
    end

    // Raster timing over two frames.
    wait_fs();
    hs_low = 0; vs_low = 0; de_cnt = 0; phs = 1'b1; pvs = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      if (i > 0) @(negedge clk);
      if (!hs) hs_low++;
      if (!vs) vs_low++;
      if (de && i < FT) de_cnt++;
      if (phs && !hs) hs_fall.push_back(i);
      if (pvs && !vs) vs_fall.push_back(i);
      phs = hs;
      pvs = vs;
    end
    hs_per = (hs_fall.size() >= 2) ? hs_fall[1] - hs_fall[0] : -1;
    vs_per = (vs_fall.size() >= 2) ? vs_fall[1] - vs_fall[0] : -1;
    check("hsync_period", hs_per, HT);
    check("hsync_low", hs_low, 2 * VT * HS);
    check("hsync_pulses", hs_fall.size(), 2 * VT);
    check("vsync_period", vs_per, FT);
    check("vsync_low", vs_low, 2 * VS * HT);
    check("display_cycles", de_cnt, HA * VA);

    // Table-driven pixel checks.
    for (int t = 0; t < 19; t++) begin
      @(posedge clk); #2 mode = tbl[t].md;
      @(posedge clk);
      wait_fs();
      repeat (tbl[t].v * HT + tbl[t].h) @(negedge clk);
      check($sformatf("tbl%0d_m%0d_v%0d_h%0d", t, tbl[t].md, tbl[t].v, tbl[t].h),
            {r, g, b}, ent_rgb(tbl[t].ent));
    end

    // Scrolling bands from a fresh reset: line 0 colour over 13 frames.
    @(posedge clk); #2 reset = 1'b0; mode = 2'd3;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int f = 0; f < 13; f++) begin
      wait_fs();
      check($sformatf("scroll_frame%0d", f), {r, g, b}, ent_rgb((f / SD) % NB));
    end

    // Mid-frame mode change is deferred; reset mid-line aborts the frame.
    @(posedge clk); #2 mode = 2'd0;
    @(posedge clk);
    wait_fs();
    repeat (5 * HT) @(negedge clk);
    mode = 2'd1;
    repeat (2 * HT) @(negedge clk);
    check("mode_held_line7", {r, g, b}, ent_rgb(2));
    repeat (10) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    #1 check("async_reset", {hs, vs, de, fs, r, g, b}, 32'hC000);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("fs_after_release", 32'(fs), 32'd1);
    check("new_frame_col0", {r, g, b}, ent_rgb(0));
    repeat (6) @(negedge clk);
    check("new_frame_mode1_col6", {r, g, b}, ent_rgb(1));

    // Random mode/palette changes and reset pulses against the model.
    for (int it = 0; it < 40; it++) begin
      act = int'($urandom_range(0, 9));
      repeat ($urandom_range(1, 250)) @(posedge clk);
      #2;
      if (act < 5) begin
        mode = 2'($urandom_range(0, 3));
      end else if (act < 8) begin
        for (int k = 0; k < NB; k++) palette[k*EW +: EW] = 12'($urandom);
      end else begin
        reset = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #2 reset = 1'b1;
      end
    end
    repeat (FT) @(negedge clk);
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
